// File: rtl/gate_trigger_pkg.sv
// rtl/gate_trigger_pkg.sv - shared constants and helpers for the gate edge trigger queue
package gate_trigger_pkg;

    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

    // Occupancy counter width: must represent 0..depth inclusive, so no wrap at full.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/trigger_fifo.sv
// rtl/trigger_fifo.sv - strict-order mask FIFO with separate occupancy counter
module trigger_fifo
    import gate_trigger_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [WIDTH-1:0]              wdata,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rdata,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [LVL_W-1:0] r_level;

    logic w_pop_acc;
    logic w_push_acc;

    assign empty      = (r_level == '0);
    assign full       = (r_level == LVL_W'(DEPTH));
    assign w_pop_acc  = pop && !empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign w_push_acc = push && (!full || w_pop_acc);

    assign rdata = empty ? '0 : r_mem[r_rptr];
    assign level = r_level;

    // Storage needs no reset: nothing is visible while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Pointers wrap modulo DEPTH (power of two); level tracks occupancy without wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push_acc) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop_acc) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_level <= r_level + LVL_W'(w_push_acc) - LVL_W'(w_pop_acc);
        end
    end

endmodule

// File: rtl/gate_edge_trigger_queue.sv
// rtl/gate_edge_trigger_queue.sv - detects gate output changes and queues change masks
module gate_edge_trigger_queue
    import gate_trigger_pkg::*;
#(
    parameter int OUTPUT_COUNT = 2,
    parameter int DEPTH        = 4
) (
    input  logic                          clk,
    input  logic                          logic_reset,
    input  logic [OUTPUT_COUNT-1:0]       in,
    output logic                          trig_valid,
    input  logic                          trig_ready,
    output logic [OUTPUT_COUNT-1:0]       trig_mask,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          overflow,
    output logic [DROP_CNT_W-1:0]         drop_count,
    input  logic                          clear_overflow
);

    logic [OUTPUT_COUNT-1:0] r_prev;
    logic                    r_primed;
    logic                    r_overflow;
    logic [DROP_CNT_W-1:0]   r_drop_count;

    logic [OUTPUT_COUNT-1:0] w_change;
    logic                    w_push_req;
    logic                    w_pop_req;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_drop;

    assign w_change   = in ^ r_prev;
    // The first edge after reset only captures a reference value.
    assign w_push_req = r_primed && (w_change != '0);
    assign w_pop_req  = trig_ready && !w_empty;
    assign w_drop     = w_push_req && w_full && !w_pop_req;

    assign trig_valid = !w_empty;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

    trigger_fifo #(
        .WIDTH (OUTPUT_COUNT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (logic_reset),
        .push  (w_push_req),
        .wdata (w_change),
        .pop   (w_pop_req),
        .rdata (trig_mask),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    // Track the previous sample and whether a reference value exists yet.
    always_ff @(posedge clk or negedge logic_reset) begin
        if (!logic_reset) begin
            r_prev   <= '0;
            r_primed <= 1'b0;
        end else begin
            r_prev   <= in;
            r_primed <= 1'b1;
        end
    end

    // Sticky overflow and saturating drop counter; a same-cycle drop beats the clear.
    always_ff @(posedge clk or negedge logic_reset) begin
        if (!logic_reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clear_overflow) begin
                r_drop_count <= DROP_CNT_W'(1);
            end else if (r_drop_count != DROP_CNT_MAX) begin
                r_drop_count <= r_drop_count + DROP_CNT_W'(1);
            end
        end else if (clear_overflow) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_gate_edge_trigger_queue.sv
// tb/tb_gate_edge_trigger_queue.sv - directed self-checking bench for gate_edge_trigger_queue
module tb_gate_edge_trigger_queue;

    logic       clk;
    logic       logic_reset;
    logic [1:0] in_s;
    logic       trig_valid;
    logic       trig_ready;
    logic [1:0] trig_mask;
    logic [2:0] level;
    logic       overflow;
    logic [7:0] drop_count;
    logic       clear_overflow;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] exp_q [$];
    logic [1:0] exp_m;

    gate_edge_trigger_queue #(
        .OUTPUT_COUNT (2),
        .DEPTH        (4)
    ) dut (
        .clk            (clk),
        .logic_reset    (logic_reset),
        .in             (in_s),
        .trig_valid     (trig_valid),
        .trig_ready     (trig_ready),
        .trig_mask      (trig_mask),
        .level          (level),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clear_overflow (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic_reset    = 1'b0;
        in_s           = 2'b11;
        trig_ready     = 1'b0;
        clear_overflow = 1'b0;
        repeat (2) @(negedge clk);

        check_eq("rst_valid", 32'(trig_valid), 32'd0);
        check_eq("rst_mask",  32'(trig_mask),  32'd0);
        check_eq("rst_level", 32'(level),      32'd0);
        check_eq("rst_ovf",   32'(overflow),   32'd0);
        check_eq("rst_drop",  32'(drop_count), 32'd0);

        logic_reset = 1'b1;
        step();
        check_eq("prime_level", 32'(level),      32'd0);
        check_eq("prime_valid", 32'(trig_valid), 32'd0);

        in_s = 2'b00;
        step();
        check_eq("chg11_valid", 32'(trig_valid), 32'd1);
        check_eq("chg11_mask",  32'(trig_mask),  32'd3);
        check_eq("chg11_level", 32'(level),      32'd1);

        trig_ready = 1'b1;
        step();
        trig_ready = 1'b0;
        check_eq("pop1_level", 32'(level),     32'd0);
        check_eq("pop1_mask",  32'(trig_mask), 32'd0);

        in_s = 2'b01;
        step();
        check_eq("lat_valid", 32'(trig_valid), 32'd1);
        check_eq("lat_mask",  32'(trig_mask),  32'd1);
        check_eq("lat_level", 32'(level),      32'd1);

        trig_ready = 1'b1;
        step();
        trig_ready = 1'b0;
        check_eq("pop2_level", 32'(level), 32'd0);

        for (int i = 0; i < 5; i++) begin
            in_s[0] = ~in_s[0];
            step();
        end
        check_eq("ovf5_level", 32'(level),      32'd4);
        check_eq("ovf5_ovf",   32'(overflow),   32'd1);
        check_eq("ovf5_drop",  32'(drop_count), 32'd1);

        for (int i = 0; i < 4; i++) begin
            check_eq("drain5_mask", 32'(trig_mask), 32'd1);
            trig_ready = 1'b1;
            step();
            trig_ready = 1'b0;
        end
        check_eq("drain5_level", 32'(level),      32'd0);
        check_eq("drain5_valid", 32'(trig_valid), 32'd0);

        in_s = 2'b01; step();
        in_s = 2'b11; step();
        in_s = 2'b10; step();
        in_s = 2'b00; step();
        check_eq("ord_level", 32'(level), 32'd4);
        exp_q = '{2'b10, 2'b01, 2'b10, 2'b11};

        trig_ready = 1'b1;
        in_s       = 2'b11;
        step();
        trig_ready = 1'b0;
        check_eq("fullpop_level", 32'(level),      32'd4);
        check_eq("fullpop_drop",  32'(drop_count), 32'd1);

        while (exp_q.size() > 0) begin
            exp_m = exp_q.pop_front();
            check_eq("ord_mask", 32'(trig_mask), 32'(exp_m));
            trig_ready = 1'b1;
            step();
            trig_ready = 1'b0;
        end
        check_eq("ord_end_level", 32'(level), 32'd0);

        for (int i = 0; i < 304; i++) begin
            in_s[0] = ~in_s[0];
            step();
        end
        check_eq("sat_drop",  32'(drop_count), 32'd255);
        check_eq("sat_ovf",   32'(overflow),   32'd1);
        check_eq("sat_level", 32'(level),      32'd4);

        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        check_eq("clr_ovf",   32'(overflow),   32'd0);
        check_eq("clr_drop",  32'(drop_count), 32'd0);
        check_eq("clr_level", 32'(level),      32'd4);

        clear_overflow = 1'b1;
        in_s           = 2'b10;
        step();
        clear_overflow = 1'b0;
        check_eq("clrdrop_ovf",  32'(overflow),   32'd1);
        check_eq("clrdrop_drop", 32'(drop_count), 32'd1);

        trig_ready = 1'b1;
        step();
        trig_ready = 1'b0;
        check_eq("pre_rst_level", 32'(level),      32'd3);
        check_eq("pre_rst_valid", 32'(trig_valid), 32'd1);

        #2;
        logic_reset = 1'b0;
        #1;
        check_eq("async_valid", 32'(trig_valid), 32'd0);
        check_eq("async_level", 32'(level),      32'd0);
        check_eq("async_mask",  32'(trig_mask),  32'd0);
        check_eq("async_ovf",   32'(overflow),   32'd0);
        check_eq("async_drop",  32'(drop_count), 32'd0);

        @(negedge clk);
        in_s        = 2'b01;
        logic_reset = 1'b1;
        step();
        check_eq("reprime_level", 32'(level),      32'd0);
        check_eq("reprime_valid", 32'(trig_valid), 32'd0);

        in_s = 2'b00;
        step();
        check_eq("post_valid", 32'(trig_valid), 32'd1);
        check_eq("post_mask",  32'(trig_mask),  32'd1);
        check_eq("post_level", 32'(level),      32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
